// File: rtl/if_stage_pkg.sv
// Shared widths, reset PC and IF->ID bus layout for the fetch stage.
package if_stage_pkg;

    localparam int          XLEN               = 32;
    localparam int          IF_TO_ID_BUS_WIDTH = 64;
    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] pc;
    } if_to_id_t;

    function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// Fetch PC and valid register with redirect/advance next-PC selection.
module if_stage_pc_reg
    import if_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_br_taken,
    input  logic [XLEN-1:0] i_br_target,
    input  logic            i_fire,
    output logic [XLEN-1:0] o_pc,
    output logic            o_valid
);

    logic [XLEN-1:0] r_pc;
    logic            r_valid;

    // Valid rises on the first edge out of reset and stays up; redirects keep it up.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc    <= RESET_PC;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b1;
            if (i_br_taken)
                r_pc <= {i_br_target[XLEN-1:2], 2'b00};
            else if (i_fire)
                r_pc <= pc_inc(r_pc);
        end
    end

    assign o_pc    = r_pc;
    assign o_valid = r_valid;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns fetch PC, hands {pc4,pc} to ID, steers synchronous IROM
// so its output matches ID's latched PC even while ID stalls.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          PC_W     = 32
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_id_allow_in,
    input  logic                          i_br_taken,
    input  logic [PC_W-1:0]               i_br_target,
    output logic [PC_W-1:0]               o_irom_addr,
    output logic [IF_TO_ID_BUS_WIDTH-1:0] o_if_to_id_bus,
    output logic                          o_if_to_id_valid,
    output logic [31:0]                   o_fetch_count,
    output logic                          o_misalign_err
);

    logic [PC_W-1:0] w_pc;
    logic            w_if_valid;
    logic            w_valid;
    logic            w_fire;
    if_to_id_t       w_bus;

    logic [PC_W-1:0] r_held_pc;
    logic [31:0]     r_fetch_count;
    logic            r_misalign_err;

    assign w_valid = w_if_valid & ~i_br_taken & ~i_rst;
    assign w_fire  = w_valid & i_id_allow_in;

    if_stage_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_br_taken  (i_br_taken),
        .i_br_target (i_br_target),
        .i_fire      (w_fire),
        .o_pc        (w_pc),
        .o_valid     (w_if_valid)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_held_pc      <= RESET_PC;
            r_fetch_count  <= 32'd0;
            r_misalign_err <= 1'b0;
        end else if (i_br_taken) begin
            r_misalign_err <= r_misalign_err | (i_br_target[1:0] != 2'b00);
        end else if (w_fire) begin
            r_held_pc     <= w_pc;
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    // IROM data arrives a cycle late: present the PC ID will hold next cycle.
    always_comb begin
        w_bus.pc  = w_pc;
        w_bus.pc4 = pc_inc(w_pc);
        if (i_rst) begin
            w_bus.pc  = RESET_PC;
            w_bus.pc4 = pc_inc(RESET_PC);
        end
    end

    assign o_irom_addr      = i_rst ? RESET_PC : (w_fire ? w_pc : r_held_pc);
    assign o_if_to_id_bus   = w_bus;
    assign o_if_to_id_valid = w_valid;
    assign o_fetch_count    = r_fetch_count;
    assign o_misalign_err   = r_misalign_err;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed cycles push expected transfers, a monitor pops them.
module tb_if_stage;
    import if_stage_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] irom;
        logic [31:0] cnt;
    } xfer_t;

    logic        clk;
    logic        rst;
    logic        allow;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] irom_addr;
    logic [63:0] bus;
    logic        valid;
    logic [31:0] fcnt;
    logic        merr;

    int    total;
    int    bad;
    xfer_t sb_q[$];

    if_stage dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_id_allow_in    (allow),
        .i_br_taken       (br),
        .i_br_target      (tgt),
        .o_irom_addr      (irom_addr),
        .o_if_to_id_bus   (bus),
        .o_if_to_id_valid (valid),
        .o_fetch_count    (fcnt),
        .o_misalign_err   (merr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; everything is sampled on the falling edge.
    task automatic step(input logic r, input logic a, input logic b, input logic [31:0] t);
        @(posedge clk);
        #1;
        rst   = r;
        allow = a;
        br    = b;
        tgt   = t;
    endtask

    task automatic expect_xfer(input logic [31:0] pc, input logic [31:0] cnt);
        xfer_t x;
        x.pc   = pc;
        x.pc4  = pc + 32'd4;
        x.irom = pc;
        x.cnt  = cnt;
        sb_q.push_back(x);
    endtask

    // Monitor: every transfer the DUT offers must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && valid && allow) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_xfer: pc %08h offered, none expected", bus[31:0]);
            end else begin
                xfer_t x;
                x = sb_q.pop_front();
                check("xfer_pc",   bus[31:0],  x.pc);
                check("xfer_pc4",  bus[63:32], x.pc4);
                check("xfer_irom", irom_addr,  x.irom);
                check("xfer_cnt",  fcnt,       x.cnt);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        allow = 1'b1;
        br    = 1'b0;
        tgt   = 32'h0;

        @(posedge clk);
        @(negedge clk);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_irom",  irom_addr,      32'h0);
        check("rst_pc",    bus[31:0],      32'h0);
        check("rst_pc4",   bus[63:32],     32'h4);
        check("rst_cnt",   fcnt,           32'd0);
        check("rst_merr",  {31'd0, merr},  32'd0);
        @(posedge clk);

        // Reset and run
        #1; rst = 1'b0;
        @(negedge clk);
        check("post_rst_valid", {31'd0, valid}, 32'd0);
        check("post_rst_irom",  irom_addr,      32'h0);
        step(0, 1, 0, 0); expect_xfer(32'h0, 0);
        step(0, 1, 0, 0); expect_xfer(32'h4, 1);
        step(0, 1, 0, 0); expect_xfer(32'h8, 2);

        // ID stall for 3 cycles
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            @(negedge clk);
            check("stall_valid", {31'd0, valid}, 32'd1);
            check("stall_pc",    bus[31:0],      32'hC);
            check("stall_pc4",   bus[63:32],     32'h10);
            check("stall_irom",  irom_addr,      32'h8);
            check("stall_cnt",   fcnt,           32'd3);
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0);
            expect_xfer(32'hC + 32'(i) * 4, 32'(3 + i));
        end

        // Redirect while pc=0x20 with ID ready
        step(0, 1, 1, 32'h100);
        @(negedge clk);
        check("br_valid", {31'd0, valid}, 32'd0);
        check("br_cnt",   fcnt,           32'd8);
        step(0, 1, 0, 0); expect_xfer(32'h100, 8);
        step(0, 1, 0, 0); expect_xfer(32'h104, 9);

        // Misaligned redirect
        step(0, 1, 1, 32'h203);
        step(0, 0, 0, 0);
        @(negedge clk);
        check("mis_pc",   bus[31:0],     32'h200);
        check("mis_pc4",  bus[63:32],    32'h204);
        check("mis_merr", {31'd0, merr}, 32'd1);
        check("mis_irom", irom_addr,     32'h104);

        // Aligned redirect to the top of the address space, then wrap
        step(0, 0, 1, 32'hFFFF_FFFC);
        step(0, 1, 0, 0); expect_xfer(32'hFFFF_FFFC, 10);
        @(negedge clk);
        check("wrap_pc4",    bus[63:32],    32'h0);
        check("sticky_merr", {31'd0, merr}, 32'd1);
        step(0, 1, 0, 0); expect_xfer(32'h0, 11);

        // Back-to-back redirects: last target wins
        step(0, 1, 1, 32'h300);
        step(0, 1, 1, 32'h40);
        step(0, 0, 0, 0);
        @(negedge clk);
        check("bb_pc",    bus[31:0],      32'h40);
        check("bb_valid", {31'd0, valid}, 32'd1);
        check("bb_irom",  irom_addr,      32'h0);
        check("bb_cnt",   fcnt,           32'd12);

        // Reset mid-stall
        step(1, 0, 0, 0);
        @(negedge clk);
        check("mid_rst_valid", {31'd0, valid}, 32'd0);
        check("mid_rst_irom",  irom_addr,      32'h0);
        check("mid_rst_pc4",   bus[63:32],     32'h4);
        step(0, 0, 0, 0);
        @(negedge clk);
        check("after_rst_valid", {31'd0, valid}, 32'd0);
        check("after_rst_pc",    bus[31:0],      32'h0);
        check("after_rst_irom",  irom_addr,      32'h0);
        check("after_rst_cnt",   fcnt,           32'd0);
        check("after_rst_merr",  {31'd0, merr},  32'd0);
        step(0, 1, 0, 0); expect_xfer(32'h0, 0);
        step(0, 0, 0, 0);
        @(negedge clk);
        check("final_cnt",     fcnt,                  32'd1);
        check("sb_drained",    32'(sb_q.size()),      32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
